register_scoreboard: RTL

Issue-stage hazard controller for the integer register file. It tracks destination registers with writes still in flight from multi-cycle units (load, mul/div, CSR). It stalls any instruction whose decoded sources or destination collide with a pending write. It also provides a drain handshake so fences and CSR writes can wait for all outstanding writebacks. It sits between the instruction decoder outputs and the execute-stage issue logic.

---
 rtl/register_scoreboard_if.sv | 36 +++
 rtl/register_scoreboard.sv | 110 +++++++++++
 2 files changed

// File: rtl/register_scoreboard_if.sv
// Issue/writeback/drain signal bundle between the decoder side and the register scoreboard.
interface register_scoreboard_if #(
    parameter int CNT_WIDTH = 3
);
    logic                 issue_valid;
    logic [4:0]           read_index_1;
    logic                 read_enable_1;
    logic [4:0]           read_index_2;
    logic                 read_enable_2;
    logic [4:0]           write_index;
    logic                 write_enable;
    logic                 long_latency;
    logic                 wb_valid;
    logic [4:0]           wb_index;
    logic                 flush;
    logic                 drain_request;
    logic                 stall;
    logic                 issue_fire;
    logic                 drain_done;
    logic [31:0]          pending;
    logic [CNT_WIDTH-1:0] outstanding;

    modport master (
        output issue_valid, read_index_1, read_enable_1, read_index_2, read_enable_2,
               write_index, write_enable, long_latency, wb_valid, wb_index, flush,
               drain_request,
        input  stall, issue_fire, drain_done, pending, outstanding
    );

    modport slave (
        input  issue_valid, read_index_1, read_enable_1, read_index_2, read_enable_2,
               write_index, write_enable, long_latency, wb_valid, wb_index, flush,
               drain_request,
        output stall, issue_fire, drain_done, pending, outstanding
    );
endinterface

// File: rtl/register_scoreboard.sv
// Issue-stage hazard scoreboard tracking in-flight long-latency register writes, with drain handshake.
// Optional feature macro: SCOREBOARD_BYPASS_EN (same-cycle writeback releases dependents).
module register_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 3
) (
    input logic                  clk,
    input logic                  reset,
    register_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);

    state_e               state_q, state_d;
    logic [31:0]          pending_q, pending_d;
    logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic                 drain_done_q, drain_done_d;

    logic [31:0]          pend_view_s;
    logic [CNT_WIDTH-1:0] cnt_view_s;
    logic                 clr_s;
    logic                 set_s;
    logic                 hazard_s;
    logic                 full_s;
    logic                 stall_s;
    logic                 fire_s;
    logic                 drain_ok_s;
    logic [31:0]          set_mask_s;
    logic [31:0]          clr_mask_s;

    // Hazard/full view of the scoreboard and the resulting issue decision
    always_comb begin
        clr_s = sb.wb_valid & pending_q[sb.wb_index];
`ifdef SCOREBOARD_BYPASS_EN
        // A writeback this cycle is visible to the issuing instruction via register-file write-through
        pend_view_s = pending_q & ~(clr_s ? (32'd1 << sb.wb_index) : 32'd0);
        cnt_view_s  = clr_s ? (outstanding_q - CNT_ONE) : outstanding_q;
        drain_ok_s  = (outstanding_q == CNT_ZERO) | ((outstanding_q == CNT_ONE) & clr_s);
`else
        pend_view_s = pending_q;
        cnt_view_s  = outstanding_q;
        drain_ok_s  = (outstanding_q == CNT_ZERO);
`endif
        hazard_s = (sb.read_enable_1 & (sb.read_index_1 != 5'd0) & pend_view_s[sb.read_index_1])
                 | (sb.read_enable_2 & (sb.read_index_2 != 5'd0) & pend_view_s[sb.read_index_2])
                 | (sb.write_enable  & (sb.write_index  != 5'd0) & pend_view_s[sb.write_index]);
        full_s   = sb.long_latency & sb.write_enable & (cnt_view_s == CNT_MAX);
        stall_s  = sb.issue_valid & (hazard_s | full_s | (state_q != ST_RUN) | sb.flush);
        fire_s   = sb.issue_valid & ~stall_s;
        set_s    = fire_s & sb.long_latency & sb.write_enable & (sb.write_index != 5'd0);
        set_mask_s = set_s ? (32'd1 << sb.write_index) : 32'd0;
        clr_mask_s = clr_s ? (32'd1 << sb.wb_index) : 32'd0;
    end

    // Next-state for pending bits, counter and drain FSM; flush overrides everything
    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        state_d       = state_q;
        drain_done_d  = 1'b0;
        if (sb.flush) begin
            pending_d     = 32'd0;
            outstanding_d = CNT_ZERO;
            state_d       = ST_RUN;
        end else begin
            // Set applied after clear so a same-index set/clear keeps the bit
            pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
            case ({set_s, clr_s})
                2'b10:   outstanding_d = outstanding_q + CNT_ONE;
                2'b01:   outstanding_d = outstanding_q - CNT_ONE;
                default: outstanding_d = outstanding_q;
            endcase
            case (state_q)
                ST_RUN:   state_d = sb.drain_request ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_d = drain_ok_s ? ST_DONE : ST_DRAIN;
                ST_DONE:  state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
        drain_done_d = (state_d == ST_DONE);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q     <= 32'd0;
            outstanding_q <= CNT_ZERO;
            state_q       <= ST_RUN;
            drain_done_q  <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            state_q       <= state_d;
            drain_done_q  <= drain_done_d;
        end
    end

    assign sb.stall       = stall_s;
    assign sb.issue_fire  = fire_s;
    assign sb.drain_done  = drain_done_q;
    assign sb.pending     = pending_q;
    assign sb.outstanding = outstanding_q;
endmodule
